// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl -- drives the EHXPLLL dynamic phase-adjust pins
// (PHASESEL/PHASEDIR/PHASESTEP) for "shift output N by K steps" requests.
// Each request gets a select/direction setup time, a train of active-low
// PHASESTEP pulses with fixed width and gap, and then a wait for PLL re-lock
// before done is reported. Runs in the PLL reference clock domain.
//
// Optional feature macro: PLL_PHASE_TRACK_EN
//   When defined, adds phase_pos[31:0]: four signed 8-bit step accumulators
//   (byte i tracks output i), +1 per lead step, -1 per lag step, wrapping.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for a request; ready only while the PLL reports lock
// S_SETUP   | phasesel/phasedir settling before the first PHASESTEP low
// S_STEP_LO | PHASESTEP held low for one step
// S_STEP_HI | PHASESTEP high gap after a step; remaining already decremented
// S_LOCKWAIT| waiting for synchronised lock, or for the lock timeout

module pll_phase_ctrl #(
  parameter int STEP_W    = 8,
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int LOCK_TO   = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep
`ifdef PLL_PHASE_TRACK_EN
  ,
  output logic [31:0]       phase_pos
`endif
);

  // A single down-counter serves every timed state, so it is sized for the
  // longest reload value (reloads are count-1, terminal count is zero).
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_SPG = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
  localparam int TMR_MAX = (MAX_SPG > LOCK_TO) ? MAX_SPG : LOCK_TO;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_LD  = TMR_W'(LOCK_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP_LO,
    S_STEP_HI,
    S_LOCKWAIT
  } state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [1:0]          sel_d;
  logic                dir_d;
  logic                done_d, err_d;
  logic                lock_meta, lock_s;
  logic                accept;

  // Two-flop synchroniser for the asynchronous PLL LOCK output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  assign req_ready = (state_q == S_IDLE) && lock_s;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, timer reload/decrement and completion pulses.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rem_d   = rem_q;
    sel_d   = phasesel;
    dir_d   = phasedir;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_d = req_sel;
          dir_d = req_dir;
          rem_d = req_steps;
          if (req_steps == '0) begin
            state_d = S_LOCKWAIT;
            tmr_d   = LOCK_LD;
          end else begin
            state_d = S_SETUP;
            tmr_d   = SETUP_LD;
          end
        end
      end
      S_SETUP: begin
        if (tmr_q == '0) begin
          state_d = S_STEP_LO;
          tmr_d   = PULSE_LD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_STEP_LO: begin
        if (tmr_q == '0) begin
          state_d = S_STEP_HI;
          tmr_d   = GAP_LD;
          rem_d   = rem_q - STEP_W'(1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_STEP_HI: begin
        if (tmr_q == '0) begin
          if (rem_q != '0) begin
            state_d = S_STEP_LO;
            tmr_d   = PULSE_LD;
          end else begin
            state_d = S_LOCKWAIT;
            tmr_d   = LOCK_LD;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_LOCKWAIT: begin
        // Lock wins a tie with the terminal count.
        if (lock_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tmr_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered PLL pins; phasestep is a flop so the PLL never
  // sees a combinational glitch and reset forces it high immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q     <= '0;
      rem_q     <= '0;
      phasesel  <= 2'd0;
      phasedir  <= 1'b1;
      phasestep <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      rem_q     <= rem_d;
      phasesel  <= sel_d;
      phasedir  <= dir_d;
      phasestep <= (state_d != S_STEP_LO);
      done      <= done_d;
      err       <= err_d;
    end
  end

`ifdef PLL_PHASE_TRACK_EN
  logic step_evt;

  // A step is counted on entry to S_STEP_HI, i.e. at the end of each low pulse.
  assign step_evt = (state_q == S_STEP_LO) && (tmr_q == '0);

  // Per-output signed step accumulators, wrapping in two's complement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_pos <= '0;
    end else if (step_evt) begin
      for (int i = 0; i < 4; i++) begin
        if (phasesel == 2'(i)) begin
          phase_pos[i*8 +: 8] <= phase_pos[i*8 +: 8] + (phasedir ? 8'h01 : 8'hFF);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl. A cycle-offset reference model
// (cycles counted from the accepting clock edge) predicts every pin.
module tb_pll_phase_ctrl;

  localparam int SETUP   = 4;
  localparam int PULSE   = 4;
  localparam int GAP     = 4;
  localparam int LOCK_TO = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
`ifdef PLL_PHASE_TRACK_EN
  logic [31:0] phase_pos;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] acc [4];

  always #5 clk = ~clk;

  pll_phase_ctrl #(
    .STEP_W(8), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .GAP_CYC(GAP), .LOCK_TO(LOCK_TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_steps(req_steps), .busy(busy), .done(done),
    .err(err), .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep)
`ifdef PLL_PHASE_TRACK_EN
    , .phase_pos(phase_pos)
`endif
  );

  // Presents a request and waits (bounded) until it is accepted on a clock edge.
  task automatic issue(input logic [1:0] s, input logic d, input logic [7:0] n);
    req_sel = s; req_dir = d; req_steps = n; req_valid = 1'b1;
    for (int w = 0; w < 60 && req_ready !== 1'b1; w++) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout ready=%b required=1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; pll_locked = 1'b0; req_valid = 1'b0;
    req_sel = 2'd0; req_dir = 1'b0; req_steps = 8'd0;
    for (int i = 0; i < 4; i++) acc[i] = 8'd0;
    #12;
    checks++;
    if ({req_ready, busy, done, err, phasesel, phasedir, phasestep} !== 8'b0000_00_1_1) begin
      errors++;
      $display("FAIL reset_values got=%b required=00000011",
               {req_ready, busy, done, err, phasesel, phasedir, phasestep});
    end
`ifdef PLL_PHASE_TRACK_EN
    checks++;
    if (phase_pos !== 32'h0) begin
      errors++;
      $display("FAIL reset_phase_pos got=%h required=00000000", phase_pos);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1; pll_locked = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_1_cycle got=%b required=0", req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, phasestep, phasedir, busy} !== 4'b1110) begin
      errors++;
      $display("FAIL ready_after_lock got=%b required=1110", {req_ready, phasestep, phasedir, busy});
    end
  endtask

  task automatic test_nominal;
    int first_lo = -1, lo_cnt = 0, pulses = 0, done_k = -1, bad_sel = 0;
    logic prev = 1'b1, err_at = 1'b0, busy_at = 1'b1, busy_before = 1'b0;
    issue(2'd2, 1'b1, 8'd3);
    for (int k = 1; k <= 60 && done_k < 0; k++) begin
      @(negedge clk);
      if (phasesel !== 2'd2 || phasedir !== 1'b1) bad_sel++;
      if (phasestep === 1'b0) begin
        lo_cnt++;
        if (first_lo < 0) first_lo = k;
        if (prev === 1'b1) pulses++;
      end
      prev = phasestep;
      if (done === 1'b1) begin
        done_k = k; err_at = err; busy_at = busy;
      end else begin
        busy_before = busy;
      end
    end
    checks++;
    if (bad_sel != 0) begin errors++; $display("FAIL nom_sel_dir bad_cycles=%0d required=0", bad_sel); end
    checks++;
    if (first_lo != SETUP + 1) begin errors++; $display("FAIL nom_first_low got=%0d required=%0d", first_lo, SETUP + 1); end
    checks++;
    if (pulses != 3 || lo_cnt != 3 * PULSE) begin
      errors++; $display("FAIL nom_pulses got=%0d/%0d required=3/%0d", pulses, lo_cnt, 3 * PULSE);
    end
    checks++;
    if (done_k != SETUP + 3 * (PULSE + GAP) + 2) begin
      errors++; $display("FAIL nom_done_cycle got=%0d required=%0d", done_k, SETUP + 3 * (PULSE + GAP) + 2);
    end
    checks++;
    if ({err_at, busy_at, busy_before} !== 3'b001) begin
      errors++; $display("FAIL nom_err_busy got=%b required=001", {err_at, busy_at, busy_before});
    end
  endtask

  task automatic test_zero_steps;
    issue(2'd1, 1'b0, 8'd0);
    @(negedge clk);
    checks++;
    if ({busy, done, err, phasestep, phasesel, phasedir} !== 7'b1001_01_0) begin
      errors++; $display("FAIL zero_k1 got=%b required=1001010", {busy, done, err, phasestep, phasesel, phasedir});
    end
    @(negedge clk);
    checks++;
    if ({busy, done, err, phasestep, phasesel, phasedir} !== 7'b0101_01_0) begin
      errors++; $display("FAIL zero_k2 got=%b required=0101010", {busy, done, err, phasestep, phasesel, phasedir});
    end
  endtask

  task automatic test_idle_lock_loss;
    int bad = 0, done_k = -1;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL idle_unlock_ready got=%b required=0", req_ready); end
    req_sel = 2'd3; req_dir = 1'b1; req_steps = 8'd2; req_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if ({req_ready, busy, done, err, phasestep} !== 5'b00001) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_unlock_quiet bad_cycles=%0d required=0", bad); end
    pll_locked = 1'b1;
    issue(2'd3, 1'b1, 8'd2);
    for (int k = 1; k <= 60 && done_k < 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_k = k;
    end
    checks++;
    if (done_k != SETUP + 2 * (PULSE + GAP) + 2 || phasesel !== 2'd3) begin
      errors++; $display("FAIL held_req_done got=%0d sel=%0d required=%0d sel=3",
                         done_k, phasesel, SETUP + 2 * (PULSE + GAP) + 2);
    end
  endtask

  // relock_k < 0: lock stays low after it drops at the first step.
  task automatic run_lockwait(input int relock_k, output int done_k, output logic err_at, output logic busy_at);
    done_k = -1; err_at = 1'b0; busy_at = 1'b1;
    pll_locked = 1'b1;
    issue(2'd0, 1'b1, 8'd2);
    for (int k = 1; k <= 80 && done_k < 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_k = k; err_at = err; busy_at = busy;
      end
      if (k == SETUP + 1) pll_locked = 1'b0;
      if (k == relock_k) pll_locked = 1'b1;
    end
  endtask

  task automatic test_timeout;
    int dk; logic e, b;
    int lw_entry = SETUP + 2 * (PULSE + GAP) + 1;
    run_lockwait(-1, dk, e, b);
    checks++;
    if (dk != lw_entry + LOCK_TO || e !== 1'b1 || b !== 1'b0) begin
      errors++; $display("FAIL lock_timeout got=%0d err=%b busy=%b required=%0d err=1 busy=0",
                         dk, e, b, lw_entry + LOCK_TO);
    end
  endtask

  task automatic test_relock;
    int dk; logic e, b;
    int relock = SETUP + 2 * (PULSE + GAP) + 1 + 5;
    run_lockwait(relock, dk, e, b);
    checks++;
    if (dk != relock + 3 || e !== 1'b0 || b !== 1'b0) begin
      errors++; $display("FAIL relock got=%0d err=%b busy=%b required=%0d err=0 busy=0", dk, e, b, relock + 3);
    end
  endtask

  // Random requests issued back to back; every cycle of every request is predicted.
  task automatic test_back_to_back;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; pll_locked = 1'b1;
    for (int i = 0; i < 4; i++) acc[i] = 8'd0;
    for (int r = 0; r < 24; r++) begin
      logic [1:0] s; logic d; logic [7:0] n; int kd;
      s = 2'($urandom_range(0, 3));
      d = 1'($urandom_range(0, 1));
      n = 8'($urandom_range(0, 6));
      kd = ((n != 0) ? SETUP + int'(n) * (PULSE + GAP) : 0) + 2;
      issue(s, d, n);
      for (int k = 1; k <= kd; k++) begin
        logic lo; logic [7:0] expv, got;
        int off = k - SETUP - 1;
        @(negedge clk);
        lo = (n != 0) && (off >= 0) && (off < int'(n) * (PULSE + GAP)) && ((off % (PULSE + GAP)) < PULSE);
        expv = {~lo, 1'(k < kd), 1'(k == kd), 1'b0, s, d, 1'(k == kd)};
        got  = {phasestep, busy, done, err, phasesel, phasedir, req_ready};
        checks++;
        if (got !== expv) begin
          errors++;
          $display("FAIL b2b_req%0d_cycle%0d got=%b required=%b (step,busy,done,err,sel,dir,ready)", r, k, got, expv);
        end
      end
      acc[s] = d ? acc[s] + n : acc[s] - n;
`ifdef PLL_PHASE_TRACK_EN
      checks++;
      if (phase_pos !== {acc[3], acc[2], acc[1], acc[0]}) begin
        errors++; $display("FAIL phase_pos_req%0d got=%h required=%h", r, phase_pos, {acc[3], acc[2], acc[1], acc[0]});
      end
`endif
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    issue(2'd1, 1'b1, 8'd3);
    for (int k = 1; k <= SETUP + PULSE + GAP + 2; k++) @(negedge clk);
    checks++;
    if (phasestep !== 1'b0) begin errors++; $display("FAIL mid_second_low got=%b required=0", phasestep); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({phasestep, busy, done, err, phasesel, phasedir} !== 7'b1000_00_1) begin
      errors++; $display("FAIL mid_reset_pins got=%b required=1000001", {phasestep, busy, done, err, phasesel, phasedir});
    end
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) bad++;
    end
    reset_n = 1'b1;
    @(negedge clk);
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) bad++;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_sync_cleared ready=%b required=0", req_ready); end
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_no_done bad_cycles=%0d ready=%b required=0 ready=1", bad, req_ready);
    end
  endtask

`ifdef PLL_PHASE_TRACK_EN
  task automatic test_track;
    int seen = 0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; pll_locked = 1'b1;
    issue(2'd1, 1'b1, 8'd5);
    for (int k = 0; k < 200 && done !== 1'b1; k++) @(negedge clk);
    if (done === 1'b1) seen++;
    issue(2'd1, 1'b0, 8'd7);
    for (int k = 0; k < 200 && done !== 1'b1; k++) @(negedge clk);
    if (done === 1'b1) seen++;
    checks++;
    if (seen != 2 || phase_pos !== 32'h0000_FE00) begin
      errors++; $display("FAIL track_lead5_lag7 got=%h done=%0d required=0000fe00 done=2", phase_pos, seen);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_zero_steps();
    test_idle_lock_loss();
    test_timeout();
    test_relock();
    test_back_to_back();
    test_reset_mid();
`ifdef PLL_PHASE_TRACK_EN
    test_track();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
